// File: rtl/baccarat_pkg.sv
// baccarat_pkg: card codes, seven-segment patterns and the card value helper
package baccarat_pkg;
    typedef logic [3:0] card_t;
    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE = 4'd1;
    localparam card_t CARD_KING = 4'd13;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_J = 7'b1100001;
    localparam logic [6:0] SEG_Q = 7'b0011000;
    localparam logic [6:0] SEG_K = 7'b0001001;
    function automatic card_t card_value(input card_t c);
        return (c <= 4'd9) ? c : CARD_EMPTY;
    endfunction
endpackage

// File: rtl/card7seg.sv
// card7seg: card code to active-low seven-segment pattern (segments g..a)
module card7seg
    import baccarat_pkg::*;
(
    input  card_t       card,
    output logic [6:0]  seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (card)
            4'd1:    seg = SEG_A;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_0;
            4'd11:   seg = SEG_J;
            4'd12:   seg = SEG_Q;
            4'd13:   seg = SEG_K;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/baccarat_datapath.sv
// baccarat_datapath: shoe, six card registers, scores and displays; SHOE_LFSR_EN selects an LFSR shoe
module baccarat_datapath
    import baccarat_pkg::*;
#(
    parameter card_t CARD_MAX = CARD_KING
`ifdef SHOE_LFSR_EN
    , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
    input  logic        slow_clock,
    input  logic        resetb,
    input  logic        load_pcard1,
    input  logic        load_pcard2,
    input  logic        load_pcard3,
    input  logic        load_dcard1,
    input  logic        load_dcard2,
    input  logic        load_dcard3,
    output card_t       pcard3_out,
    output logic [3:0]  pscore_out,
    output logic [3:0]  dscore_out,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);
    card_t new_card, next_card;
    card_t pcard [3];
    card_t dcard [3];
    logic [2:0] pload, dload;
    logic [4:0] psum, dsum;

    assign pload = {load_pcard3, load_pcard2, load_pcard1};
    assign dload = {load_dcard3, load_dcard2, load_dcard1};

`ifdef SHOE_LFSR_EN
    logic [15:0] lfsr;
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) lfsr <= LFSR_SEED;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    // out-of-range nibbles leave the previous card in the shoe
    assign next_card = (lfsr[3:0] >= CARD_ACE && lfsr[3:0] <= CARD_MAX) ? lfsr[3:0] : new_card;
`else
    assign next_card = (new_card == CARD_MAX) ? CARD_ACE : new_card + 4'd1;
`endif

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            new_card <= CARD_ACE;
            pcard <= '{default: CARD_EMPTY};
            dcard <= '{default: CARD_EMPTY};
        end else begin
            new_card <= next_card;
            for (int i = 0; i < 3; i++) begin
                if (pload[i]) pcard[i] <= new_card;
                if (dload[i]) dcard[i] <= new_card;
            end
        end
    end

    assign psum = {1'b0, card_value(pcard[0])} + {1'b0, card_value(pcard[1])} + {1'b0, card_value(pcard[2])};
    assign dsum = {1'b0, card_value(dcard[0])} + {1'b0, card_value(dcard[1])} + {1'b0, card_value(dcard[2])};
    assign pscore_out = 4'(psum % 5'd10);
    assign dscore_out = 4'(dsum % 5'd10);
    assign pcard3_out = pcard[2];

    card7seg u_hex0 (.card(pcard[0]), .seg(HEX0));
    card7seg u_hex1 (.card(pcard[1]), .seg(HEX1));
    card7seg u_hex2 (.card(pcard[2]), .seg(HEX2));
    card7seg u_hex3 (.card(dcard[0]), .seg(HEX3));
    card7seg u_hex4 (.card(dcard[1]), .seg(HEX4));
    card7seg u_hex5 (.card(dcard[2]), .seg(HEX5));
endmodule

// File: tb/tb_baccarat_datapath.sv
// tb_baccarat_datapath: table-driven deal vectors plus random loads against a shoe/score model
module tb_baccarat_datapath;
    logic slow_clock = 1'b0;
    logic resetb = 1'b0;
    logic [5:0] ld = '0;
    logic [3:0] pcard3_out, pscore_out, dscore_out;
    logic [6:0] hex [6];
    int checks = 0;
    int errors = 0;
    int e = 0;
    int mp [3];
    int md [3];
    int s1 [40];
    int s2 [40];

    typedef struct {
        int edge_no;
        logic [5:0] ld;
        int p1, p2, p3, d1, d2, d3, ps, ds;
    } vec_t;
    vec_t tab [10];

    always #5 slow_clock = ~slow_clock;

    baccarat_datapath dut (
        .slow_clock(slow_clock), .resetb(resetb),
        .load_pcard1(ld[5]), .load_pcard2(ld[4]), .load_pcard3(ld[3]),
        .load_dcard1(ld[2]), .load_dcard2(ld[1]), .load_dcard3(ld[0]),
        .pcard3_out(pcard3_out), .pscore_out(pscore_out), .dscore_out(dscore_out),
        .HEX0(hex[0]), .HEX1(hex[1]), .HEX2(hex[2]),
        .HEX3(hex[3]), .HEX4(hex[4]), .HEX5(hex[5])
    );

    function automatic logic [6:0] seg(int c);
        case (c)
            1: return 7'b0001000;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            10: return 7'b1000000;
            11: return 7'b1100001;
            12: return 7'b0011000;
            13: return 7'b0001001;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int val(int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, " pscore"}, pscore_out, 0);
        chk({tag, " dscore"}, dscore_out, 0);
        chk({tag, " pcard3"}, pcard3_out, 0);
        for (int i = 0; i < 6; i++) chk($sformatf("%s hex%0d", tag, i), hex[i], 7'h7F);
    endtask

    task automatic check_cards(string tag, int p1, int p2, int p3, int d1, int d2, int d3, int ps, int ds);
        chk({tag, " pscore"}, pscore_out, ps);
        chk({tag, " dscore"}, dscore_out, ds);
        chk({tag, " pcard3"}, pcard3_out, p3);
        chk({tag, " hex0"}, hex[0], seg(p1));
        chk({tag, " hex1"}, hex[1], seg(p2));
        chk({tag, " hex2"}, hex[2], seg(p3));
        chk({tag, " hex3"}, hex[3], seg(d1));
        chk({tag, " hex4"}, hex[4], seg(d2));
        chk({tag, " hex5"}, hex[5], seg(d3));
    endtask

    task automatic check_model(string tag);
        check_cards(tag, mp[0], mp[1], mp[2], md[0], md[1], md[2],
                    (val(mp[0]) + val(mp[1]) + val(mp[2])) % 10,
                    (val(md[0]) + val(md[1]) + val(md[2])) % 10);
    endtask

    // called at a negedge; the model shoe deals card k%13+1 on the k-th edge after reset (k from 0)
    task automatic step(logic [5:0] l);
        int card;
        ld = l;
        @(posedge slow_clock);
        card = e % 13 + 1;
        for (int i = 0; i < 3; i++) begin
            if (l[5 - i]) mp[i] = card;
            if (l[2 - i]) md[i] = card;
        end
        e++;
        @(negedge slow_clock);
        ld = '0;
    endtask

    task automatic apply_reset();
        #2 resetb = 1'b0;
        #1 check_zero("async_reset");
        @(posedge slow_clock);
        @(posedge slow_clock);
        @(negedge slow_clock);
        check_zero("held_reset");
        resetb = 1'b1;
        e = 0;
        for (int i = 0; i < 3; i++) begin
            mp[i] = 0;
            md[i] = 0;
        end
    endtask

    task automatic run_lfsr(int which);
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            step(6'b001000);
            checks++;
            if (pcard3_out < 1 || pcard3_out > 13) begin
                errors++;
                $display("FAIL lfsr_range run%0d idx%0d: got %0d expected 1..13", which, i, pcard3_out);
            end
            if (which == 1) s1[i] = pcard3_out;
            else s2[i] = pcard3_out;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tab[0] = '{1,  6'b100000, 1, 0, 0,  0,  0,  0, 1, 0};
        tab[1] = '{7,  6'b010000, 1, 7, 0,  0,  0,  0, 8, 0};
        tab[2] = '{13, 6'b000100, 1, 7, 0,  13, 0,  0, 8, 0};
        tab[3] = '{14, 6'b000010, 1, 7, 0,  13, 1,  0, 8, 1};
        tab[4] = '{20, 6'b100000, 7, 7, 0,  13, 1,  0, 4, 1};
        tab[5] = '{21, 6'b010000, 7, 8, 0,  13, 1,  0, 5, 1};
        tab[6] = '{23, 6'b000001, 7, 8, 0,  13, 1,  10, 5, 1};
        tab[7] = '{24, 6'b001000, 7, 8, 11, 13, 1,  10, 5, 1};
        tab[8] = '{25, 6'b000010, 7, 8, 11, 13, 12, 10, 5, 0};
        tab[9] = '{27, 6'b001001, 7, 8, 1,  13, 12, 1,  6, 1};
        @(negedge slow_clock);
        apply_reset();
`ifndef SHOE_LFSR_EN
        for (int r = 0; r < 10; r++) begin
            while (e < tab[r].edge_no - 1) step(6'b000000);
            step(tab[r].ld);
            check_cards($sformatf("vec%0d", r), tab[r].p1, tab[r].p2, tab[r].p3,
                        tab[r].d1, tab[r].d2, tab[r].d3, tab[r].ps, tab[r].ds);
        end
        repeat (20) step(6'b000000);
        check_cards("hold20", 7, 8, 1, 13, 12, 1, 6, 1);
        check_model("hold20_model");
        for (int i = 0; i < 300; i++) begin
            logic [5:0] l;
            for (int b = 0; b < 6; b++) l[b] = ($urandom_range(3) == 0);
            step(l);
            check_model($sformatf("rand%0d", i));
        end
        apply_reset();
        step(6'b100000);
        chk("restart pcard1", hex[0], 7'b0001000);
        chk("restart pscore", pscore_out, 1);
        for (int i = 0; i < 60; i++) begin
            step(6'($urandom));
            check_model($sformatf("rand_post%0d", i));
        end
`else
        run_lfsr(1);
        repeat (7) step(6'b111111);
        run_lfsr(2);
        for (int i = 0; i < 40; i++) chk($sformatf("lfsr_repeat%0d", i), s2[i], s1[i]);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
